vec_pair_packer: RTL and testbench

VEC_PAIR_PACKER -- requirements
Module: vec_pair_packer

---
 rtl/vec_dot_pkg.sv | 13 +
 rtl/vec_lane_reg.sv | 24 ++
 rtl/vec_pair_packer.sv | 117 +++++++++++
 tb/tb_vec_pair_packer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vec_dot_pkg.sv
// Shared definitions for the dot-product front end: default vector geometry
// and the packer FSM state encoding.
package vec_dot_pkg;

  localparam int unsigned VEC_N      = 8;
  localparam int unsigned VEC_ELEM_W = 8;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } vec_state_e;

endpackage

// File: rtl/vec_lane_reg.sv
// One element lane of a packed vector. A write takes priority over the
// clear so a new vector's lane 0 can load while its neighbours clear.
module vec_lane_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/vec_pair_packer.sv
// Packs a stream of (a, b) element pairs into two lane-aligned vectors and
// presents them to the dot-product datapath with a valid/ready handshake.
module vec_pair_packer
  import vec_dot_pkg::*;
#(
  parameter int unsigned N      = VEC_N,
  parameter int unsigned ELEM_W = VEC_ELEM_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ELEM_W-1:0]          in_elem_a,
  input  logic [ELEM_W-1:0]          in_elem_b,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N*ELEM_W-1:0]        vec_a,
  output logic [N*ELEM_W-1:0]        vec_b,
  output logic [$clog2(N+1)-1:0]     out_count,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  vec_state_e       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wr_idx;
  logic             in_xfer;
  logic             out_xfer;
  logic             done;
  logic             lane_we;
  logic             lane_clr;
  logic [N-1:0]     lane_sel;

  assign in_ready  = (state_q == S_FILL) ? 1'b1 : out_ready;
  assign out_valid = (state_q == S_HOLD);
  assign out_count = cnt_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // A pair accepted in HOLD always starts the next vector at lane 0.
  assign wr_idx = (state_q == S_HOLD) ? '0 : idx_q;
  assign done   = in_last || (wr_idx == CNT_W'(N - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    lane_we  = in_xfer;
    lane_clr = 1'b0;
    case (state_q)
      S_FILL: begin
        if (in_xfer) begin
          if (done) begin
            state_d = S_HOLD;
            cnt_d   = idx_q + CNT_W'(1);
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (out_xfer) begin
          lane_clr = 1'b1;
          state_d  = S_FILL;
          idx_d    = '0;
          cnt_d    = '0;
          if (in_xfer) begin
            idx_d = CNT_W'(1);
            if (done) begin
              state_d = S_HOLD;
              cnt_d   = CNT_W'(1);
            end
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lane_sel[k] = lane_we && (wr_idx == CNT_W'(k));

    vec_lane_reg #(.W(ELEM_W)) u_lane_a (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_sel[k]),
      .clr   (lane_clr),
      .d     (in_elem_a),
      .q     (vec_a[k*ELEM_W +: ELEM_W])
    );

    vec_lane_reg #(.W(ELEM_W)) u_lane_b (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (lane_sel[k]),
      .clr   (lane_clr),
      .d     (in_elem_b),
      .q     (vec_b[k*ELEM_W +: ELEM_W])
    );
  end

endmodule

// File: tb/tb_vec_pair_packer.sv
// Directed bench for vec_pair_packer with N = 8, ELEM_W = 8.
module tb_vec_pair_packer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_elem_a;
  logic [7:0]  in_elem_b;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] vec_a;
  logic [63:0] vec_b;
  logic [3:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  vec_pair_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_elem_a (in_elem_a),
    .in_elem_b (in_elem_b),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_a     (vec_a),
    .vec_b     (vec_b),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One transfer cycle; inputs are driven 1 time unit after an edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    in_elem_a = a;
    in_elem_b = b;
    in_last   = last;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    int          nvec;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_elem_a = '0; in_elem_b = '0;
    #12 rst_n = 1'b1;
    idle();

    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_vec_a", vec_a, 64'd0);
    chk("rst_vec_b", vec_b, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Full vector
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send(8'(i), 8'(i), 1'b0);
    chk("full_valid_before_8th", 64'(out_valid), 64'd0);
    send(8'd8, 8'd8, 1'b0);
    chk("full_valid", 64'(out_valid), 64'd1);
    chk("full_vec_a", vec_a, 64'h0807060504030201);
    chk("full_vec_b", vec_b, 64'h0807060504030201);
    chk("full_count", 64'(out_count), 64'd8);
    idle();
    chk("full_drained_valid", 64'(out_valid), 64'd0);
    chk("full_drained_clear", vec_a, 64'd0);

    // Early last
    send(8'd5, 8'd3, 1'b0);
    send(8'd7, 8'd2, 1'b1);
    chk("early_valid", 64'(out_valid), 64'd1);
    chk("early_vec_a", vec_a, 64'h0705);
    chk("early_vec_b", vec_b, 64'h0203);
    chk("early_count", 64'(out_count), 64'd2);
    idle();

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(8'h11 + i), 8'(8'h21 + i), 1'b0);
    chk("bp_valid", 64'(out_valid), 64'd1);
    in_elem_a = 8'hAA; in_elem_b = 8'hBB; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_vec_a_stable", vec_a, 64'h1817161514131211);
      chk("bp_vec_b_stable", vec_b, 64'h2827262524232221);
      chk("bp_count_stable", 64'(out_count), 64'd8);
      idle();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_pass", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_after_valid", 64'(out_valid), 64'd0);
    chk("bp_lane0_a", vec_a, 64'h00000000000000AA);
    chk("bp_lane0_b", vec_b, 64'h00000000000000BB);
    send(8'hCC, 8'hDD, 1'b1);
    chk("bp_next_vec_a", vec_a, 64'hCCAA);
    chk("bp_next_vec_b", vec_b, 64'hDDBB);
    chk("bp_next_count", 64'(out_count), 64'd2);
    idle();

    // Streaming: 32 pairs back to back
    nvec = 0;
    in_valid = 1'b1; in_last = 1'b0;
    for (int k = 0; k < 32; k++) begin
      in_elem_a = 8'(k);
      in_elem_b = 8'(k + 8'h80);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk("stream_valid", 64'(out_valid), 64'((k % 8) == 7));
      if ((k % 8) == 7) begin
        for (int j = 0; j < 8; j++) begin
          exp_a[j*8 +: 8] = 8'(k - 7 + j);
          exp_b[j*8 +: 8] = 8'(k - 7 + j + 8'h80);
        end
        chk("stream_vec_a", vec_a, exp_a);
        chk("stream_vec_b", vec_b, exp_b);
        chk("stream_count", 64'(out_count), 64'd8);
        if (out_valid) nvec++;
      end
    end
    in_valid = 1'b0;
    chk("stream_nvec", 64'(nvec), 64'd4);
    idle();
    chk("stream_drained", 64'(out_valid), 64'd0);

    // Reset mid-fill
    send(8'd1, 8'd2, 1'b0);
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    chk("rmf_partial_a", vec_a, 64'h050301);
    #2 rst_n = 1'b0;
    #1;
    chk("rmf_valid", 64'(out_valid), 64'd0);
    chk("rmf_vec_a", vec_a, 64'd0);
    chk("rmf_vec_b", vec_b, 64'd0);
    chk("rmf_count", 64'(out_count), 64'd0);
    #1 rst_n = 1'b1;
    idle();
    send(8'h09, 8'h0A, 1'b1);
    chk("rmf_next_valid", 64'(out_valid), 64'd1);
    chk("rmf_next_a", vec_a, 64'h09);
    chk("rmf_next_b", vec_b, 64'h0A);
    chk("rmf_next_count", 64'(out_count), 64'd1);
    idle();

    // Single-element vector
    send(8'hFF, 8'hFF, 1'b1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_vec_a", vec_a, 64'hFF);
    chk("single_vec_b", vec_b, 64'hFF);
    chk("single_count", 64'(out_count), 64'd1);
    idle();
    chk("single_drained", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
